// File: rtl/pc_predict_unit.sv
// pc_predict_unit
// IF-stage PC generator for the 5-stage MIPS pipeline. It holds the fetch PC
// and predicts the next one through a direct-mapped BTB with 2-bit counters.
// It also takes branch/jump resolutions from ID, repairs mispredictions and
// trains the BTB.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   stall           hold the fetch PC (ignored when a mispredict is repaired)
//   pc_o            registered fetch PC
//   pred_taken_o    prediction for pc_o (combinational BTB lookup)
//   pred_target_o   predicted next PC for pc_o
//   id_valid        ID holds a resolved control-transfer instruction
//   id_kind         00 none, 01 beq/bne, 10 j/jal, 11 jr
//   id_pc           PC of the ID instruction
//   id_taken        actual outcome
//   id_target       actual target
//   id_pred_taken   prediction carried down with the instruction
//   id_pred_target  predicted target carried down with it
//   flush_o         kill the instruction currently in IF
module pc_predict_unit #(
  parameter int               WIDTH    = 32,
  parameter int               BTB_IDX  = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 'h0000_3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [WIDTH-1:0] pc_o,
  output logic             pred_taken_o,
  output logic [WIDTH-1:0] pred_target_o,
  input  logic             id_valid,
  input  logic [1:0]       id_kind,
  input  logic [WIDTH-1:0] id_pc,
  input  logic             id_taken,
  input  logic [WIDTH-1:0] id_target,
  input  logic             id_pred_taken,
  input  logic [WIDTH-1:0] id_pred_target,
  output logic             flush_o
);

  localparam int               ENTRIES = 1 << BTB_IDX;
  localparam int               TAG_W   = WIDTH - BTB_IDX - 2;
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  localparam logic [1:0] KIND_BRANCH = 2'b01;

  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [ENTRIES-1:0] valid_q, valid_d;

  // BTB payload arrays. These are not reset: the valid bits gate every use.
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [1:0]       kind_q   [ENTRIES];
  logic [WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // Single write port used for training.
  logic               wr_en;
  logic [BTB_IDX-1:0] wr_idx;
  logic [TAG_W-1:0]   tag_d;
  logic [1:0]         kind_d;
  logic [WIDTH-1:0]   target_d;
  logic [1:0]         ctr_d;

  logic [BTB_IDX-1:0] rd_idx;
  logic               rd_hit;
  logic [WIDTH-1:0]   pc_plus4;
  logic               upd_hit;
  logic               train;
  logic               mispredict;

  // Lookup reads the registered arrays. A same-cycle training write to the
  // same index therefore only becomes visible on the next cycle.
  assign rd_idx   = pc_q[BTB_IDX+1:2];
  assign rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == pc_q[WIDTH-1:BTB_IDX+2]);
  assign pc_plus4 = pc_q + PC_STEP;

  // Jumps are always predicted taken on a hit. Branches follow the counter MSB.
  assign pred_taken_o  = rd_hit && ((kind_q[rd_idx] != KIND_BRANCH) || ctr_q[rd_idx][1]);
  assign pred_target_o = pred_taken_o ? target_q[rd_idx] : pc_plus4;
  assign pc_o          = pc_q;

  assign mispredict = id_valid && (id_kind != 2'b00) &&
                      ((id_taken != id_pred_taken) ||
                       (id_taken && (id_target != id_pred_target)));
  assign flush_o    = mispredict;

  // Next PC. A repair has priority over a stall, so a hazard cannot hold a
  // wrong-path PC in IF.
  always_comb begin
    pc_d = pred_target_o;
    if (mispredict) begin
      pc_d = id_taken ? id_target : (id_pc + PC_STEP);
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  assign wr_idx  = id_pc[BTB_IDX+1:2];
  assign upd_hit = valid_q[wr_idx] && (tag_q[wr_idx] == id_pc[WIDTH-1:BTB_IDX+2]);
  assign train   = id_valid && (id_kind != 2'b00);

  // Training. A hit refreshes kind and target (the target only when taken)
  // and steps the counter. A taken miss allocates the entry and overwrites
  // any alias. A not-taken miss leaves the BTB alone.
  always_comb begin
    wr_en    = 1'b0;
    valid_d  = valid_q;
    tag_d    = id_pc[WIDTH-1:BTB_IDX+2];
    kind_d   = id_kind;
    target_d = target_q[wr_idx];
    ctr_d    = ctr_q[wr_idx];
    if (train) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (id_taken) begin
          target_d = id_target;
        end
        if (id_kind == KIND_BRANCH) begin
          if (id_taken && (ctr_q[wr_idx] != 2'b11)) begin
            ctr_d = ctr_q[wr_idx] + 2'd1;
          end else if (!id_taken && (ctr_q[wr_idx] != 2'b00)) begin
            ctr_d = ctr_q[wr_idx] - 2'd1;
          end
        end else begin
          ctr_d = 2'b11;
        end
      end else if (id_taken) begin
        wr_en           = 1'b1;
        valid_d[wr_idx] = 1'b1;
        target_d        = id_target;
        ctr_d           = (id_kind == KIND_BRANCH) ? 2'b10 : 2'b11;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_q[wr_idx]    <= tag_d;
      kind_q[wr_idx]   <= kind_d;
      target_q[wr_idx] <= target_d;
      ctr_q[wr_idx]    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit
// Directed bench for pc_predict_unit. A bench-side model of the BTB and fetch
// PC is compared against the DUT on every falling edge. Hand-computed literals
// at key points pin the model itself.
module tb_pc_predict_unit;

  localparam int          N      = 16;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst, stall, id_valid, id_taken, id_pred_taken;
  logic [1:0]  id_kind;
  logic [31:0] id_pc, id_target, id_pred_target;
  logic [31:0] pc_o, pred_target_o;
  logic        pred_taken_o, flush_o;

  int tests_run    = 0;
  int tests_failed = 0;

  pc_predict_unit #(.WIDTH(32), .BTB_IDX(4), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .pc_o           (pc_o),
    .pred_taken_o   (pred_taken_o),
    .pred_target_o  (pred_target_o),
    .id_valid       (id_valid),
    .id_kind        (id_kind),
    .id_pc          (id_pc),
    .id_taken       (id_taken),
    .id_target      (id_target),
    .id_pred_taken  (id_pred_taken),
    .id_pred_target (id_pred_target),
    .flush_o        (flush_o)
  );

  always #5 clk = ~clk;

  // Model state: each slot remembers the full PC that last wrote it, so a hit
  // is "same PC bits above the index".
  logic [31:0] m_pc;
  bit          m_valid [N];
  logic [31:0] m_owner [N];
  logic [31:0] m_tgt   [N];
  int          m_kind  [N];
  int          m_ctr   [N];
  bit          model_ready = 1'b0;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(N));
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int i = slot_of(pc);
    return m_valid[i] && ((pc >> 6) == (m_owner[i] >> 6));
  endfunction

  function automatic bit model_taken(input logic [31:0] pc);
    int i = slot_of(pc);
    return model_hit(pc) && (m_kind[i] != 1 || m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc);
    return model_taken(pc) ? m_tgt[slot_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit model_mispredict();
    if (!id_valid || id_kind == 2'b00) return 1'b0;
    if (id_taken != id_pred_taken) return 1'b1;
    return id_taken && (id_target != id_pred_target);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Model update on the rising edge, from the inputs held across the edge.
  always @(posedge clk) begin : model_update
    int          i;
    logic [31:0] nxt;
    if (rst) begin
      m_pc = RST_PC;
      for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
      model_ready = 1'b1;
    end else begin
      if (model_mispredict())
        nxt = id_taken ? id_target : id_pc + 32'd4;
      else if (stall)
        nxt = m_pc;
      else
        nxt = model_target(m_pc);
      if (id_valid && id_kind != 2'b00) begin
        i = slot_of(id_pc);
        if (model_hit(id_pc)) begin
          m_kind[i] = int'(id_kind);
          if (id_taken) m_tgt[i] = id_target;
          if (id_kind == 2'b01)
            m_ctr[i] = id_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
          else
            m_ctr[i] = 3;
        end else if (id_taken) begin
          m_valid[i] = 1'b1;
          m_owner[i] = id_pc;
          m_kind[i]  = int'(id_kind);
          m_tgt[i]   = id_target;
          m_ctr[i]   = (id_kind == 2'b01) ? 2 : 3;
        end
      end
      m_pc = nxt;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("pc_o",          pc_o,                   m_pc);
      checkOutput("pred_taken_o",  {31'd0, pred_taken_o},  {31'd0, model_taken(m_pc)});
      checkOutput("pred_target_o", pred_target_o,          model_target(m_pc));
      checkOutput("flush_o",       {31'd0, flush_o},       {31'd0, model_mispredict()});
    end
  end

  task automatic applyStimulus(input bit r, input bit s, input bit v,
                               input logic [1:0] k, input logic [31:0] ipc,
                               input bit t, input logic [31:0] tgt,
                               input bit pt, input logic [31:0] ptgt);
    rst            = r;
    stall          = s;
    id_valid       = v;
    id_kind        = k;
    id_pc          = ipc;
    id_taken       = t;
    id_target      = tgt;
    id_pred_taken  = pt;
    id_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steer fetch to pc by resolving a not-taken branch at pc-4 that was
  // predicted taken. pc-4 is never resident, so this does not train.
  task automatic redirect(input logic [31:0] pc);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, pc - 32'd4, 1'b0, 32'd0, 1'b1, pc);
    step();
    idle();
  endtask

  initial begin : watchdog
    #100000;
    tests_failed++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    // Reset held for two edges, then three free-running fetches.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    step();
    step();
    idle();
    checkOutput("reset_pc",   pc_o,                  32'h3000);
    checkOutput("reset_pred", {31'd0, pred_taken_o}, 32'd0);
    step();
    checkOutput("seq_3004",   pc_o,                  32'h3004);
    step();
    checkOutput("seq_3008",   pc_o,                  32'h3008);
    checkOutput("seq_pred",   {31'd0, pred_taken_o}, 32'd0);

    // Taken beq mispredicted as not taken: flush, redirect, allocate with ctr=10.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 32'h3008, 1'b1, 32'h3020, 1'b0, 32'h300C);
    checkOutput("beq_flush", {31'd0, flush_o}, 32'd1);
    step();
    checkOutput("beq_redirect", pc_o, 32'h3020);
    idle();
    redirect(32'h3008);
    checkOutput("beq_pred_taken",  {31'd0, pred_taken_o}, 32'd1);
    checkOutput("beq_pred_target", pred_target_o,         32'h3020);

    // Not-taken three times with correct predictions: 10 -> 01 -> 00 -> 00.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 32'h3008, 1'b0, 32'd0, 1'b0, 32'h300C);
    checkOutput("nt_no_flush", {31'd0, flush_o}, 32'd0);
    step();
    step();
    step();
    idle();
    redirect(32'h3008);
    checkOutput("nt_pred_taken",  {31'd0, pred_taken_o}, 32'd0);
    checkOutput("nt_pred_target", pred_target_o,         32'h300C);

    // A jr mispredict overrides a stall.
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 32'h3010, 1'b1, 32'h4000, 1'b0, 32'h3014);
    checkOutput("jr_flush", {31'd0, flush_o}, 32'd1);
    step();
    checkOutput("jr_redirect", pc_o, 32'h4000);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int n = 0; n < 3; n++) begin
      step();
      checkOutput("stall_hold", pc_o, 32'h4000);
    end
    idle();

    // jr predicts the last target. A matching target is not a mispredict;
    // a different target is.
    redirect(32'h3010);
    checkOutput("jr_pred_taken",  {31'd0, pred_taken_o}, 32'd1);
    checkOutput("jr_pred_target", pred_target_o,         32'h4000);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 32'h3010, 1'b1, 32'h4000, 1'b1, 32'h4000);
    checkOutput("jr_match_no_flush", {31'd0, flush_o}, 32'd0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 32'h3010, 1'b1, 32'h4100, 1'b1, 32'h4000);
    checkOutput("jr_target_flush", {31'd0, flush_o}, 32'd1);
    step();
    checkOutput("jr_target_redirect", pc_o, 32'h4100);

    // id_kind 00 never flushes, even with a disagreeing prediction.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h3010, 1'b1, 32'h5555, 1'b0, 32'd0);
    checkOutput("kind00_no_flush", {31'd0, flush_o}, 32'd0);
    step();
    idle();

    // Aliasing: a taken j at 0x3048 overwrites the entry used by 0x3008.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 32'h3048, 1'b1, 32'h5000, 1'b0, 32'h304C);
    step();
    checkOutput("alias_redirect", pc_o, 32'h5000);
    idle();
    redirect(32'h3008);
    checkOutput("alias_3008_miss", {31'd0, pred_taken_o}, 32'd0);
    redirect(32'h3048);
    checkOutput("alias_3048_hit",    {31'd0, pred_taken_o}, 32'd1);
    checkOutput("alias_3048_target", pred_target_o,         32'h5000);

    // pc+4 wraps modulo 2^32.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 32'h2000, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h2004);
    step();
    idle();
    checkOutput("wrap_pc",     pc_o,          32'hFFFF_FFFC);
    checkOutput("wrap_target", pred_target_o, 32'h0000_0000);
    step();
    checkOutput("wrap_next", pc_o, 32'h0000_0000);

    // Reset mid-run beats a concurrent mispredict and invalidates the BTB.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b10, 32'h3000, 1'b1, 32'h7000, 1'b0, 32'h3004);
    step();
    checkOutput("midrst_pc", pc_o, 32'h3000);
    idle();
    redirect(32'h3010);
    checkOutput("midrst_jr_miss",   {31'd0, pred_taken_o}, 32'd0);
    redirect(32'h3048);
    checkOutput("midrst_j_miss",    {31'd0, pred_taken_o}, 32'd0);
    checkOutput("midrst_j_target",  pred_target_o,         32'h304C);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
